mcu_timer: RTL



---
 rtl/mcu_timer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mcu_timer.sv
// Memory-mapped prescaled 32-bit timer with compare/auto-reload, sticky W1C flags and interrupt.
// Optional PWM output and duty register at 0x14 when MCU_TIMER_PWM_EN is defined.
module mcu_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdat_i,
    output logic [31:0] rdat_o,
    output logic        sel_o,
    output logic        irq_o,
    output logic        pwm_o
);

    localparam logic [5:0] OFF_CTRL   = 6'd0;
    localparam logic [5:0] OFF_PRESC  = 6'd1;
    localparam logic [5:0] OFF_COUNT  = 6'd2;
    localparam logic [5:0] OFF_CMP    = 6'd3;
    localparam logic [5:0] OFF_STATUS = 6'd4;
`ifdef MCU_TIMER_PWM_EN
    localparam logic [5:0] OFF_PWM    = 6'd5;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q,   cmp_d;
    logic        match_q, match_d;
    logic        ovf_q,   ovf_d;
    logic [15:0] psc_q,   psc_d;

    logic [5:0]  off;
    logic        wr_en;
    logic        tick;
    logic        cmp_hit;
    logic        unused_addr_bits;

    assign sel_o            = (addr_i[31:8] == BASE_ADDR[31:8]);
    assign off              = addr_i[7:2];
    assign wr_en            = we_i & sel_o;
    assign tick             = ctrl_q[0] && (psc_q == presc_q);
    assign cmp_hit          = (count_q == cmp_q);
    assign unused_addr_bits = ^addr_i[1:0];

`ifdef MCU_TIMER_PWM_EN
    logic [31:0] pwm_q, pwm_d;
    logic        pwm_out_q, pwm_out_d;
`endif

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        ovf_d   = ovf_q;
        psc_d   = psc_q;
`ifdef MCU_TIMER_PWM_EN
        pwm_d     = pwm_q;
        pwm_out_d = ctrl_q[0] && (count_q < pwm_q);
`endif

        if (!ctrl_q[0] || tick) begin
            psc_d = 16'd0;
        end else begin
            psc_d = psc_q + 16'd1;
        end

        // W1C clears are applied first so a simultaneous hardware set wins
        if (wr_en && off == OFF_STATUS && be_i[0]) begin
            if (wdat_i[0]) match_d = 1'b0;
            if (wdat_i[1]) ovf_d   = 1'b0;
        end

        if (tick) begin
            if (cmp_hit) begin
                match_d = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = 32'd0;
                end else begin
                    count_d = count_q + 32'd1;
                    if (count_q == 32'hFFFF_FFFF) ovf_d = 1'b1;
                end
            end else if (count_q == 32'hFFFF_FFFF) begin
                count_d = 32'd0;
                ovf_d   = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_en) begin
            case (off)
                OFF_CTRL:  if (be_i[0]) ctrl_d = wdat_i[2:0];
                OFF_PRESC: begin
                    presc_d = merge_bytes({16'd0, presc_q}, wdat_i, be_i) >> 0;
                    psc_d   = 16'd0;
                end
                OFF_COUNT: count_d = merge_bytes(count_q, wdat_i, be_i);
                OFF_CMP:   cmp_d   = merge_bytes(cmp_q, wdat_i, be_i);
`ifdef MCU_TIMER_PWM_EN
                OFF_PWM:   pwm_d   = merge_bytes(pwm_q, wdat_i, be_i);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            psc_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            psc_q   <= psc_d;
        end
    end

`ifdef MCU_TIMER_PWM_EN
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            pwm_q     <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_q     <= pwm_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_o = pwm_out_q;
`else
    assign pwm_o = 1'b0;
`endif

    assign irq_o = ctrl_q[2] & (match_q | ovf_q);

    always_comb begin
        rdat_o = 32'd0;
        if (sel_o) begin
            case (off)
                OFF_CTRL:   rdat_o = {29'd0, ctrl_q};
                OFF_PRESC:  rdat_o = {16'd0, presc_q};
                OFF_COUNT:  rdat_o = count_q;
                OFF_CMP:    rdat_o = cmp_q;
                OFF_STATUS: rdat_o = {30'd0, ovf_q, match_q};
`ifdef MCU_TIMER_PWM_EN
                OFF_PWM:    rdat_o = pwm_q;
`endif
                default:    rdat_o = 32'd0;
            endcase
        end
    end

endmodule
